// File: rtl/switch_box_pkg.sv
// switch_box_pkg
//   Shared constants for the configurable switch box.
//   - SIDE_L/U/R/D : side indices, clockwise starting at the left side
//   - SEL_*        : 2-bit source-select encodings per output track
//   - cfg_idx()    : LSB position of the select field for side s, track t
package switch_box_pkg;

    localparam int SIDE_L = 0;
    localparam int SIDE_U = 1;
    localparam int SIDE_R = 2;
    localparam int SIDE_D = 3;

    // Sources are counted clockwise from the output side, so an output can
    // never pick its own side.
    localparam logic [1:0] SEL_OFF  = 2'b00;
    localparam logic [1:0] SEL_NEXT = 2'b01;
    localparam logic [1:0] SEL_OPP  = 2'b10;
    localparam logic [1:0] SEL_PREV = 2'b11;

    function automatic int cfg_idx(input int s, input int t, input int w);
        return 2 * (s * w + t);
    endfunction

endpackage

// File: rtl/switch_box_track_mux.sv
// switch_box_track_mux
//   W-bit, per-track 4:1 source select for one output side.
//   Ports:
//     sel    [2*W-1:0] : select field, track t uses sel[2t+1:2t]
//     nxt_in [W-1:0]   : tracks of the next side (clockwise)
//     opp_in [W-1:0]   : tracks of the opposite side
//     prv_in [W-1:0]   : tracks of the previous side
//     y      [W-1:0]   : routed output tracks (track t only from track t)
module switch_box_track_mux
    import switch_box_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2*W-1:0] sel,
    input  logic [W-1:0]   nxt_in,
    input  logic [W-1:0]   opp_in,
    input  logic [W-1:0]   prv_in,
    output logic [W-1:0]   y
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_track
            always_comb begin
                y[gi] = 1'b0;
                case (sel[2*gi +: 2])
                    SEL_NEXT: y[gi] = nxt_in[gi];
                    SEL_OPP:  y[gi] = opp_in[gi];
                    SEL_PREV: y[gi] = prv_in[gi];
                    default:  y[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/switch_box_cfg.sv
// switch_box_cfg
//   Serially configured switch box with W tracks on each of four sides.
//   A shadow shift register collects an 8*W-bit frame; a load commits it to
//   the active configuration only when exactly CFG_BITS bits were shifted
//   since the previous load attempt and no shift happens on the load cycle.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     si, se, so            : serial config in, shift enable, serial out
//     cfg_load              : commit request for the shadow frame
//     l/u/r/d_in  [W-1:0]   : track inputs per side
//     l/u/r/d_out [W-1:0]   : track outputs per side (combinational)
//     cfg_valid             : a complete frame has been committed
//     cfg_err               : sticky, last load attempt was malformed
module switch_box_cfg
    import switch_box_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         si,
    input  logic         se,
    input  logic         cfg_load,
    output logic         so,
    input  logic [W-1:0] l_in,
    input  logic [W-1:0] u_in,
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] l_out,
    output logic [W-1:0] u_out,
    output logic [W-1:0] r_out,
    output logic [W-1:0] d_out,
    output logic         cfg_valid,
    output logic         cfg_err
);

    localparam int CFG_BITS = 8 * W;
    // Counter must reach CFG_BITS+1 so overlong frames stay distinguishable.
    localparam int CW = $clog2(CFG_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] sr_reg;
    logic [CFG_BITS-1:0] active_reg;
    logic [CW-1:0]       bit_cnt_reg;
    logic                cfg_valid_reg;
    logic                cfg_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg        <= '0;
            active_reg    <= '0;
            bit_cnt_reg   <= '0;
            cfg_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            if (se) begin
                sr_reg <= {sr_reg[CFG_BITS-2:0], si};
            end

            if (cfg_load) begin
                bit_cnt_reg <= '0;
            end else if (se && (bit_cnt_reg != CNT_SAT)) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            // A load on a shifting cycle is rejected: the frame is in motion.
            if (cfg_load) begin
                if (!se && (bit_cnt_reg == CNT_FULL)) begin
                    active_reg    <= sr_reg;
                    cfg_valid_reg <= 1'b1;
                    cfg_err_reg   <= 1'b0;
                end else begin
                    cfg_err_reg   <= 1'b1;
                end
            end
        end
    end

    assign so        = sr_reg[CFG_BITS-1];
    assign cfg_valid = cfg_valid_reg;
    assign cfg_err   = cfg_err_reg;

    logic [W-1:0] side_in  [4];
    logic [W-1:0] side_out [4];

    assign side_in[SIDE_L] = l_in;
    assign side_in[SIDE_U] = u_in;
    assign side_in[SIDE_R] = r_in;
    assign side_in[SIDE_D] = d_in;

    assign l_out = side_out[SIDE_L];
    assign u_out = side_out[SIDE_U];
    assign r_out = side_out[SIDE_R];
    assign d_out = side_out[SIDE_D];

    // Each side's select fields are contiguous, so one slice feeds one mux;
    // the input ordering rotates with the output side.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_side
            switch_box_track_mux #(.W(W)) u_mux (
                .sel    (active_reg[cfg_idx(gi, 0, W) +: 2*W]),
                .nxt_in (side_in[(gi + 1) % 4]),
                .opp_in (side_in[(gi + 2) % 4]),
                .prv_in (side_in[(gi + 3) % 4]),
                .y      (side_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_switch_box_cfg.sv
module tb_switch_box_cfg;

    localparam int W  = 4;
    localparam int CB = 8 * W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic si = 1'b0, se = 1'b0, cfg_load = 1'b0;
    logic [W-1:0] l_in = '0, u_in = '0, r_in = '0, d_in = '0;
    logic [W-1:0] l_out, u_out, r_out, d_out;
    logic so, cfg_valid, cfg_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: shifted-bit history, frame-length count, flags.
    bit            q[$];
    int            m_cnt = 0;
    logic [CB-1:0] m_active = '0;
    logic          m_valid = 1'b0;
    logic          m_err = 1'b0;

    always #5 clk = ~clk;

    switch_box_cfg #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .si(si), .se(se), .cfg_load(cfg_load),
        .so(so),
        .l_in(l_in), .u_in(u_in), .r_in(r_in), .d_in(d_in),
        .l_out(l_out), .u_out(u_out), .r_out(r_out), .d_out(d_out),
        .cfg_valid(cfg_valid), .cfg_err(cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output of side s: sources counted clockwise, same track only.
    function automatic logic [W-1:0] exp_out(input int s);
        logic [W-1:0] ins [4];
        logic [W-1:0] r;
        int sel;
        ins[0] = l_in; ins[1] = u_in; ins[2] = r_in; ins[3] = d_in;
        r = '0;
        for (int t = 0; t < W; t++) begin
            sel = int'(m_active[2*(s*W+t) +: 2]);
            if (sel != 0) r[t] = ins[(s + sel) % 4][t];
        end
        return r;
    endfunction

    // so is the bit shifted in CB shifts ago (zero before that many shifts).
    function automatic logic exp_so();
        return (q.size() == CB) ? q[0] : 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_active = '0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        if (cfg_load) begin
            if (!se && m_cnt == CB) begin
                for (int i = 0; i < CB; i++) m_active[i] = q[CB-1-i];
                m_valid = 1'b1;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end else if (se) begin
            m_cnt = (m_cnt + 1 > CB + 1) ? CB + 1 : m_cnt + 1;
        end
        if (se) begin
            q.push_back(si);
            if (q.size() > CB) void'(q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #2;
    endtask

    task automatic shift_bits(input logic [CB-1:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            si = v[i]; se = 1'b1;
            tick();
        end
        se = 1'b0; si = 1'b0;
    endtask

    task automatic load();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        $display("load: cfg_valid=%0b cfg_err=%0b l=%h u=%h r=%h d=%h",
                 cfg_valid, cfg_err, l_out, u_out, r_out, d_out);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " l_out"}, 32'(l_out), 32'h0);
        chk({tag, " u_out"}, 32'(u_out), 32'h0);
        chk({tag, " r_out"}, 32'(r_out), 32'h0);
        chk({tag, " d_out"}, 32'(d_out), 32'h0);
        chk({tag, " so"}, 32'(so), 32'h0);
        chk({tag, " cfg_valid"}, 32'(cfg_valid), 32'h0);
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'h0);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("l_out", 32'(l_out), 32'(exp_out(0)));
        chk("u_out", 32'(u_out), 32'(exp_out(1)));
        chk("r_out", 32'(r_out), 32'(exp_out(2)));
        chk("d_out", 32'(d_out), 32'(exp_out(3)));
        chk("so", 32'(so), 32'(exp_so()));
        chk("cfg_valid", 32'(cfg_valid), 32'(m_valid));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    end

    initial begin
        logic [31:0] cap;

        // Reset with l_in driven: everything stays at zero.
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        l_in = 4'hF;
        #1 chk_all_zero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // r_out tracks all select the opposite side (l).
        shift_bits(32'h00AA_0000, 32);
        l_in = 4'hA;
        load();
        chk("commit model r_out", 32'(exp_out(2)), 32'hA);
        chk("commit r_out", 32'(r_out), 32'hA);
        chk("commit l_out", 32'(l_out), 32'h0);
        chk("commit d_out", 32'(d_out), 32'h0);
        chk("commit cfg_valid", 32'(cfg_valid), 32'h1);
        chk("commit cfg_err", 32'(cfg_err), 32'h0);

        // Short frame: rejected, routing and valid retained.
        shift_bits(32'hFFFF_FFFF, 31);
        load();
        chk("short cfg_err", 32'(cfg_err), 32'h1);
        chk("short r_out", 32'(r_out), 32'hA);
        chk("short u_out", 32'(u_out), 32'h0);
        chk("short cfg_valid", 32'(cfg_valid), 32'h1);

        // Load while shifting after 31 shifts: rejected, count restarts.
        shift_bits(32'hFFFF_FFFF, 31);
        cfg_load = 1'b1; se = 1'b1; si = 1'b1;
        tick();
        cfg_load = 1'b0; se = 1'b0; si = 1'b0;
        chk("load+se cfg_err", 32'(cfg_err), 32'h1);
        chk("load+se r_out", 32'(r_out), 32'hA);
        // A fresh 32-bit frame now commits: d_out takes next side (l).
        shift_bits(32'h5500_0000, 32);
        load();
        chk("recount cfg_err", 32'(cfg_err), 32'h0);
        chk("recount d_out", 32'(d_out), 32'hA);
        chk("recount r_out", 32'(r_out), 32'h0);

        // Overlong frame: rejected.
        shift_bits(32'h0000_00FF, 32);
        shift_bits(32'h0, 1);
        load();
        chk("long cfg_err", 32'(cfg_err), 32'h1);
        chk("long d_out", 32'(d_out), 32'hA);

        // Serial pass-through: so reproduces the first word MSB-first.
        shift_bits(32'hDEAD_BEEF, 32);
        cap = '0;
        for (int i = 0; i < 32; i++) begin
            cap = {cap[30:0], so};
            si = 1'($urandom); se = 1'b1;
            tick();
        end
        se = 1'b0; si = 1'b0;
        chk("so stream", cap, 32'hDEAD_BEEF);
        $display("so stream captured %h", cap);

        // Random frames and inputs, checked by the model every cycle.
        for (int f = 0; f < 6; f++) begin
            shift_bits(CB'($urandom), 32);
            load();
            for (int k = 0; k < 4; k++) begin
                l_in = W'($urandom); u_in = W'($urandom);
                r_in = W'($urandom); d_in = W'($urandom);
                tick();
            end
        end

        // Asynchronous reset in the middle of shifting bit 16.
        l_in = 4'hF; u_in = 4'hF; r_in = 4'hF; d_in = 4'hF;
        shift_bits(32'hFFFF_FFFF, 32);
        load();
        shift_bits(32'h1234_5678, 15);
        si = 1'b1; se = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_all_zero("async reset");
        se = 1'b0; si = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        l_in = 4'hA; u_in = 4'h0; r_in = 4'h0; d_in = 4'h0;
        shift_bits(32'h00AA_0000, 32);
        load();
        chk("post-reset r_out", 32'(r_out), 32'hA);
        chk("post-reset cfg_valid", 32'(cfg_valid), 32'h1);
        chk("post-reset cfg_err", 32'(cfg_err), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_box_cfg.md
SWITCH_BOX_CFG -- requirements
Module: switch_box_cfg

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the number of routing tracks per side (legal range 1..16).
REQ-002 The block SHALL have localparam CFG_BITS, equal to 8*W, giving the configuration frame length in bits.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and is the reset: asynchronous, active-low.
REQ-005 Port si SHALL be an input, 1 bit wide, and is the serial configuration data in.
REQ-006 Port se SHALL be an input, 1 bit wide, and is the shift enable.
REQ-007 Port cfg_load SHALL be an input, 1 bit wide, and is a request to commit the shadow frame to the active configuration.
REQ-008 Port so SHALL be an output, 1 bit wide, and is the serial configuration data out, for chaining to the next box.
REQ-009 Ports l_in, u_in, r_in and d_in SHALL be inputs, W bits wide each, and are the track inputs per side.
REQ-010 Ports l_out, u_out, r_out and d_out SHALL be outputs, W bits wide each, and are the track outputs per side.
REQ-011 Port cfg_valid SHALL be an output, 1 bit wide, and is high while a committed, complete frame is active.
REQ-012 Port cfg_err SHALL be an output, 1 bit wide, and is a sticky flag for the last load attempt being malformed.

Function
REQ-013 Shadow register sr[CFG_BITS-1:0] SHALL shift when se=1: sr <= {sr[CFG_BITS-2:0], si}.
REQ-014 Output so SHALL equal sr[CFG_BITS-1], giving CFG_BITS cycles of delay si->so.
REQ-015 Counter bit_cnt SHALL increment on each se=1 cycle and saturate at CFG_BITS+1.
REQ-016 bit_cnt SHALL clear on any cycle with cfg_load=1.
REQ-017 When cfg_load=1, se=0 and bit_cnt==CFG_BITS, then on that clock edge: active <= sr, cfg_valid <= 1, cfg_err <= 0.
REQ-018 When cfg_load=1, se=0 and bit_cnt!=CFG_BITS (short or overlong frame): active is unchanged, cfg_valid is unchanged, cfg_err <= 1.
REQ-019 When cfg_load=1 and se=1 in the same cycle: the shift occurs, the load is rejected and cfg_err <= 1.
REQ-020 Shifting SHALL never alter active or the route outputs; the shadow/active split guarantees glitch-free reconfiguration.
REQ-021 Field layout: side index s (l=0, u=1, r=2, d=3) and track t use active[2*(s*W+t)+1 : 2*(s*W+t)].
REQ-022 Source select per output track, taking sources clockwise from the output side:
- 00: drive 0.
- 01: next side.
- 10: opposite side.
- 11: previous side.
REQ-023 The select mapping per output side SHALL be:
- l_out: 01=u, 10=r, 11=d.
- u_out: 01=r, 10=d, 11=l.
- r_out: 01=d, 10=l, 11=u.
- d_out: 01=l, 10=u, 11=r.
REQ-024 Output track t SHALL select input track t of the chosen side only; there is no track permutation.
REQ-025 Route outputs SHALL be combinational from active and the inputs, with zero cycles of latency.
REQ-026 An output SHALL never select its own side.

Reset
REQ-027 On rst_n=0, immediately and independent of clk: sr=0, active=0, bit_cnt=0, cfg_valid=0, cfg_err=0.
REQ-028 Consequently all *_out SHALL be 0 and so SHALL be 0 during reset.
REQ-029 Reset asserted mid-shift SHALL discard the partial frame; the first edge after release starts a new frame.
REQ-030 Reset release SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-031 Package switch_box_pkg SHALL hold:
- the side index constants SIDE_L/U/R/D;
- the select encodings SEL_OFF/NEXT/OPP/PREV;
- the field-index function cfg_idx(s, t, W).
REQ-032 Sub-module switch_box_track_mux SHALL implement the W-bit 4:1 select for one output side, instantiated 4 times with rotated input ordering.
REQ-033 The sequential logic (sr, bit_cnt, active, flags) SHALL reside in switch_box_cfg only.

Verification (W=4, CFG_BITS=32)
REQ-034 Scenario: reset, then hold l_in=4'hF -> all outputs 4'h0; cfg_valid=0; cfg_err=0; so=0.
REQ-035 Scenario: shift 32 bits setting r_out all tracks=10 (from l) and the others 00, then pulse cfg_load, l_in=4'hA -> r_out=4'hA next cycle; others 0; cfg_valid=1.
REQ-036 Scenario: shift 31 bits, then cfg_load -> cfg_err=1; routing unchanged from the prior frame; cfg_valid unchanged.
REQ-037 Scenario: cfg_load together with se=1 after exactly 31 prior shifts -> cfg_err=1; no commit; bit_cnt=0 afterwards.
REQ-038 Scenario: shift a 32-bit pattern 0xDEADBEEF followed by 32 more bits -> so reproduces 0xDEADBEEF MSB-first, beginning at shift cycle 33.
REQ-039 Scenario: assert rst_n=0 between clock edges during shift bit 16 -> outputs and flags clear immediately; a following full 32-bit frame and load commits correctly.
